// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: control and count-bus bundle for count_seq_ctrl
// master: start/stop/pause/load/load_val/modulus/auto_reload out; q/busy/done/state in
// slave:  the mirror image, used by the counter controller
interface count_seq_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             stop;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [1:0]       state;
    modport master(
        output start, stop, pause, load, load_val, modulus, auto_reload,
        input  q, busy, done, state
    );
    modport slave(
        input  start, stop, pause, load, load_val, modulus, auto_reload,
        output q, busy, done, state
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencer for a WIDTH-bit modulo counter with start/stop/pause/load
// clk, rst (async, active-high); bus: control inputs and registered q/busy/done/state
module count_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    count_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    state_t           st, st_n;
    logic [WIDTH-1:0] q_r, q_n, mod_r, mod_n, term;
    logic             mode_r, mode_n, done_r, done_n, busy_r, idle_done, over;
    // modulus 0 means the full 2**WIDTH range, so its terminal wraps to all ones
    assign term      = mod_r - 1'b1;
    assign idle_done = (st == IDLE) || (st == DONE);
    // load is checked against the live modulus since mod_r is only captured at start
    assign over      = (bus.modulus != '0) && (bus.load_val >= bus.modulus);
    always_comb begin
        st_n   = st;
        q_n    = q_r;
        done_n = 1'b0;
        mod_n  = mod_r;
        mode_n = mode_r;
        if (bus.stop) begin
            st_n = IDLE;
            q_n  = '0;
        end else if (bus.load && idle_done) begin
            q_n = over ? '0 : bus.load_val;
        end else if (st == RUN) begin
            if (bus.pause) begin
                st_n = PAUSE;
            end else if (q_r == term) begin
                q_n    = '0;
                done_n = 1'b1;
                st_n   = mode_r ? RUN : DONE;
            end else begin
                q_n = q_r + 1'b1;
            end
        end else if (st == PAUSE) begin
            st_n = bus.pause ? PAUSE : RUN;
        end else if (bus.start) begin
            st_n   = RUN;
            mod_n  = bus.modulus;
            mode_n = bus.auto_reload;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            q_r    <= '0;
            mod_r  <= '0;
            mode_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            st     <= st_n;
            q_r    <= q_n;
            mod_r  <= mod_n;
            mode_r <= mode_n;
            done_r <= done_n;
            busy_r <= (st_n == RUN) || (st_n == PAUSE);
        end
    end
    assign bus.q     = q_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = st;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: scoreboard bench for count_seq_ctrl
module tb_count_seq_ctrl;
    typedef struct packed {
        logic [3:0] q;
        logic [1:0] st;
        logic       busy;
        logic       done;
    } obs_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    obs_t sb [$];
    count_seq_ctrl_if #(.WIDTH(4)) bus();
    count_seq_ctrl #(.WIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic obs_t cur();
        return {bus.q, bus.state, bus.busy, bus.done};
    endfunction
    // expected outputs from {q, state, done}; busy follows the state encoding
    function automatic obs_t mk(logic [6:0] v);
        return {v[6:3], v[2:1], (v[2:1] == 2'd1) || (v[2:1] == 2'd2), v[0]};
    endfunction
    // entry layout: {stop,load,pause,start}[19:16] auto[15] mod[14:11] load_val[10:7] q[6:3] st[2:1] done[0]
    task automatic apply(logic [19:0] e);
        {bus.stop, bus.load, bus.pause, bus.start} = e[19:16];
        bus.auto_reload = e[15];
        bus.modulus     = e[14:11];
        bus.load_val    = e[10:7];
    endtask
    task automatic test_reset;
        obs_t g, x;
        apply('0);
        #2 rst = 1'b1;
        #1 checks++;
        if (cur() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_assert got %h want 00", cur());
        end
        tick;
        checks++;
        if (cur() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_hold got %h want 00", cur());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply({3'b000, i == 0, 1'b1, 4'd0, 4'd0, 7'd0});
            sb.push_back(mk({i[3:0], 2'd1, 1'b0}));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL reset_prerun[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
        #3 rst = 1'b1;
        #1 checks++;
        if (cur() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_async got %h want 00", cur());
        end
        tick;
        checks++;
        if (cur() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_midrun_hold got %h want 00", cur());
        end
        rst = 1'b0;
    endtask
    task automatic test_oneshot;
        logic [19:0] t [$];
        obs_t g, x;
        t = '{
            {4'b0001, 1'b0, 4'd5, 4'd0, 4'd0, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd3, 4'd0, 4'd1, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd3, 4'd0, 4'd2, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd3, 4'd0, 4'd3, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd3, 4'd0, 4'd4, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd3, 4'd0, 4'd0, 2'd3, 1'b1},
            {4'b0000, 1'b1, 4'd3, 4'd0, 4'd0, 2'd3, 1'b0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i][6:0]));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL oneshot[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
    endtask
    task automatic test_full_range;
        obs_t g, x;
        logic [3:0] eq;
        for (int i = 0; i < 19; i++) begin
            apply({i == 18, 2'b00, i == 0, i == 0, i == 0 ? 4'd0 : 4'd9, 4'd0, 7'd0});
            eq = (i == 0 || i >= 16) ? 4'd0 : i[3:0];
            if (i == 17) eq = 4'd1;
            sb.push_back(mk({eq, i == 18 ? 2'd0 : 2'd1, i == 16}));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL full_range[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
    endtask
    task automatic test_pause;
        logic [19:0] t [$];
        obs_t g, x;
        t = '{
            {4'b0001, 1'b1, 4'd0, 4'd0, 4'd0, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd1, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd2, 2'd1, 1'b0},
            {4'b0010, 1'b1, 4'd0, 4'd0, 4'd2, 2'd2, 1'b0},
            {4'b0010, 1'b1, 4'd0, 4'd0, 4'd2, 2'd2, 1'b0},
            {4'b0010, 1'b1, 4'd0, 4'd0, 4'd2, 2'd2, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd2, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd3, 2'd1, 1'b0},
            {4'b1000, 1'b1, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0},
            {4'b0001, 1'b0, 4'd3, 4'd0, 4'd0, 2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd3, 4'd0, 4'd1, 2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd3, 4'd0, 4'd2, 2'd1, 1'b0},
            {4'b0010, 1'b0, 4'd3, 4'd0, 4'd2, 2'd2, 1'b0},
            {4'b0000, 1'b0, 4'd3, 4'd0, 4'd2, 2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd3, 4'd0, 4'd0, 2'd3, 1'b1}
        };
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i][6:0]));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL pause[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
    endtask
    task automatic test_load;
        logic [19:0] t [$];
        obs_t g, x;
        t = '{
            {4'b1000, 1'b0, 4'd10, 4'd0,  4'd0,  2'd0, 1'b0},
            {4'b0100, 1'b0, 4'd10, 4'd7,  4'd7,  2'd0, 1'b0},
            {4'b0001, 1'b0, 4'd10, 4'd7,  4'd7,  2'd1, 1'b0},
            {4'b0100, 1'b0, 4'd10, 4'd3,  4'd8,  2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd10, 4'd0,  4'd9,  2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd10, 4'd0,  4'd0,  2'd3, 1'b1},
            {4'b0100, 1'b0, 4'd10, 4'd5,  4'd5,  2'd3, 1'b0},
            {4'b0100, 1'b0, 4'd10, 4'd12, 4'd0,  2'd3, 1'b0},
            {4'b0100, 1'b0, 4'd0,  4'd15, 4'd15, 2'd3, 1'b0},
            {4'b0101, 1'b0, 4'd10, 4'd4,  4'd4,  2'd3, 1'b0},
            {4'b0100, 1'b0, 4'd10, 4'd10, 4'd0,  2'd3, 1'b0},
            {4'b0100, 1'b0, 4'd10, 4'd9,  4'd9,  2'd3, 1'b0},
            {4'b0001, 1'b0, 4'd10, 4'd0,  4'd9,  2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd10, 4'd0,  4'd0,  2'd3, 1'b1}
        };
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i][6:0]));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL load[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
    endtask
    task automatic test_mod1;
        logic [19:0] t [$];
        obs_t g, x;
        t = '{
            {4'b0001, 1'b1, 4'd1, 4'd0, 4'd0, 2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd1, 4'd0, 4'd0, 2'd1, 1'b1},
            {4'b0000, 1'b1, 4'd1, 4'd0, 4'd0, 2'd1, 1'b1},
            {4'b0000, 1'b0, 4'd1, 4'd0, 4'd0, 2'd1, 1'b1},
            {4'b1000, 1'b0, 4'd1, 4'd0, 4'd0, 2'd0, 1'b0},
            {4'b0001, 1'b0, 4'd1, 4'd0, 4'd0, 2'd1, 1'b0},
            {4'b0000, 1'b0, 4'd1, 4'd0, 4'd0, 2'd3, 1'b1},
            {4'b0000, 1'b0, 4'd1, 4'd0, 4'd0, 2'd3, 1'b0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i][6:0]));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL mod1[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
    endtask
    task automatic test_back_to_back;
        logic [19:0] t [$];
        obs_t g, x;
        t = '{
            {4'b0001, 1'b1, 4'd0, 4'd0, 4'd0,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd1,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd2,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd3,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd4,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd5,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd6,  2'd1, 1'b0},
            {4'b1111, 1'b1, 4'd0, 4'd5, 4'd0,  2'd0, 1'b0},
            {4'b0001, 1'b1, 4'd0, 4'd0, 4'd0,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd1,  2'd1, 1'b0},
            {4'b0001, 1'b1, 4'd0, 4'd0, 4'd2,  2'd1, 1'b0},
            {4'b0011, 1'b1, 4'd0, 4'd0, 4'd2,  2'd2, 1'b0},
            {4'b1010, 1'b1, 4'd0, 4'd0, 4'd0,  2'd0, 1'b0},
            {4'b0101, 1'b1, 4'd0, 4'd9, 4'd9,  2'd0, 1'b0},
            {4'b0001, 1'b1, 4'd0, 4'd0, 4'd9,  2'd1, 1'b0},
            {4'b0000, 1'b1, 4'd0, 4'd0, 4'd10, 2'd1, 1'b0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i][6:0]));
            tick;
            g = cur();
            x = sb.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL back_to_back[%0d] got q=%0d st=%0d busy=%b done=%b want q=%0d st=%0d busy=%b done=%b",
                         i, g.q, g.st, g.busy, g.done, x.q, x.st, x.busy, x.done);
            end
        end
    endtask
    initial begin
        test_reset;
        test_oneshot;
        test_full_range;
        test_pause;
        test_load;
        test_mod1;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
